// File: rtl/filter_spad_seq.sv
// filter_spad_seq: self-addressing filter-weight scratchpad for a PE.
// A LOAD phase streams a filter row in over a valid/ready handshake.
// A READ phase then replays it one weight per rd_en request, for
// cfg_reuse passes (0 counts as 1).
// Optional feature macro: FSPAD_ZERO_FLAG_EN. When it is defined, rd_zero
// flags all-zero weights. When it is undefined, rd_zero is tied low.
module filter_spad_seq #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic [7:0]        cfg_reuse,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              rd_zero,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ} state_t;

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W:0]     r_len;
    logic [7:0]          r_reuse;
    logic [7:0]          r_pass;
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W-1:0]   r_rptr;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_rd_last;
    logic                r_done;
    logic                r_err;

    logic                w_cfg_ok;
    logic [ADDR_W:0]     w_last_idx;
    logic                w_wr_end;
    logic                w_rd_end;
    logic                w_accept;
    logic                w_reject;
    logic                w_wr_fire;
    logic                w_rd_fire;
    logic                w_final;

    assign w_cfg_ok   = (cfg_len != '0) && (cfg_len <= LP_DEPTH);
    assign w_last_idx = r_len - 1'b1;
    assign w_wr_end   = ({1'b0, r_wptr} == w_last_idx);
    assign w_rd_end   = ({1'b0, r_rptr} == w_last_idx);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-cycle transfer strobes
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_reject  = 1'b0;
        w_wr_fire = 1'b0;
        w_rd_fire = 1'b0;
        w_final   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_cfg_ok) begin
                        w_accept = 1'b1;
                        w_next   = S_LOAD;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (wr_valid) begin
                    w_wr_fire = 1'b1;
                    if (w_wr_end) begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ: begin
                if (rd_en) begin
                    w_rd_fire = 1'b1;
                    if (w_rd_end && (r_pass == r_reuse - 8'd1)) begin
                        w_final = 1'b1;
                        w_next  = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Job configuration, pointers, pass counter and registered read outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_reuse    <= '0;
            r_pass     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            r_rd_last  <= w_rd_fire && w_rd_end;
            r_done     <= w_final;
            r_err      <= w_reject;
            if (w_accept) begin
                r_len   <= cfg_len;
                r_reuse <= (cfg_reuse == 8'd0) ? 8'd1 : cfg_reuse;
                r_pass  <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
            end
            if (w_wr_fire) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_fire) begin
                r_rd_data <= r_mem[r_rptr];
                if (w_rd_end) begin
                    r_rptr <= '0;
                    r_pass <= r_pass + 8'd1;
                end else begin
                    r_rptr <= r_rptr + 1'b1;
                end
            end
        end
    end

    // Weight storage; deliberately not reset so contents persist across jobs
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

`ifdef FSPAD_ZERO_FLAG_EN
    logic r_rd_zero;

    // Zero flag registered alongside rd_data so the PE can gate its multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_zero <= 1'b0;
        end else begin
            r_rd_zero <= w_rd_fire && (r_mem[r_rptr] == '0);
        end
    end

    assign rd_zero = r_rd_zero;
`else
    assign rd_zero = 1'b0;
`endif

    assign wr_ready = (r_state == S_LOAD);
    assign busy     = (r_state != S_IDLE);
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_last  = r_rd_last;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_filter_spad_seq.sv
// Directed, table-driven bench for filter_spad_seq.
// Cycle vectors cover the basic job, backpressure and illegal configs.
// Hand-written sequences cover reset mid-READ and a full-depth job.
module tb_filter_spad_seq;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
`ifdef FSPAD_ZERO_FLAG_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   cfg_len;
    logic [7:0]        cfg_reuse;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_en;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_zero;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    filter_spad_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
        .cfg_reuse(cfg_reuse), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_last(rd_last), .rd_zero(rd_zero),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [6:0] len;
        logic [7:0] reuse;
        logic       wv;
        logic [7:0] wd;
        logic       re;
        logic       e_wr_ready;
        logic       e_rd_valid;
        logic [7:0] e_rd_data;
        logic       e_rd_last;
        logic       e_rd_zero;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, input int len, input int reuse,
                       input logic wv, input int wd, input logic re,
                       input logic ewr, input logic ev, input int ed,
                       input logic el, input logic ez, input logic eb,
                       input logic edn, input logic ee);
        vec_t v;
        v.st = st; v.len = 7'(len); v.reuse = 8'(reuse);
        v.wv = wv; v.wd = 8'(wd); v.re = re;
        v.e_wr_ready = ewr; v.e_rd_valid = ev; v.e_rd_data = 8'(ed);
        v.e_rd_last = el; v.e_rd_zero = ez && ZEN; v.e_busy = eb;
        v.e_done = edn; v.e_err = ee;
        tbl.push_back(v);
    endtask

    function automatic logic [14:0] outs();
        return {wr_ready, rd_valid, rd_last, rd_zero, busy, done, err, rd_data};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, then step past the next rising edge.
    task automatic drive(input logic st, input int len, input int reuse,
                         input logic wv, input int wd, input logic re);
        @(negedge clk);
        start = st; cfg_len = 7'(len); cfg_reuse = 8'(reuse);
        wr_valid = wv; wr_data = 8'(wd); rd_en = re;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int nreads;
        int ndone;
        logic [14:0] exp;

        rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_reuse = '0;
        wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0;
        #1;
        chk("reset_state {wr_ready,rd_valid,rd_last,rd_zero,busy,done,err,rd_data}", 32'(outs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic job: len=3 reuse=2 {5,0,7}, with ignored inputs folded in
        add(1, 3, 2,   0, 0,    0,  1, 0, 0, 0, 0, 1, 0, 0);
        add(0, 3, 2,   1, 5,    0,  1, 0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 2,   1, 0,    1,  1, 0, 0, 0, 0, 1, 0, 0);  // start/rd_en in LOAD
        add(0, 3, 2,   1, 7,    0,  0, 0, 0, 0, 0, 1, 0, 0);  // last write -> READ
        add(0, 5, 9,   0, 0,    1,  0, 1, 5, 0, 0, 1, 0, 0);  // cfg change mid-job
        add(0, 3, 2,   1, 8'hAA,1,  0, 1, 0, 0, 1, 1, 0, 0);  // wr_valid in READ
        add(0, 3, 2,   0, 0,    1,  0, 1, 7, 1, 0, 1, 0, 0);
        add(0, 3, 2,   0, 0,    1,  0, 1, 5, 0, 0, 1, 0, 0);
        add(0, 3, 2,   0, 0,    1,  0, 1, 0, 0, 1, 1, 0, 0);
        add(0, 3, 2,   0, 0,    1,  0, 1, 7, 1, 0, 0, 1, 0);  // final read
        // Backpressure/bubbles: new start right at K+1, len=4 reuse=1
        add(1, 4, 1,   0, 0,    0,  1, 0, 7, 0, 0, 1, 0, 0);
        add(0, 4, 1,   1, 11,   0,  1, 0, 7, 0, 0, 1, 0, 0);
        add(0, 4, 1,   0, 99,   0,  1, 0, 7, 0, 0, 1, 0, 0);
        add(0, 4, 1,   1, 22,   0,  1, 0, 7, 0, 0, 1, 0, 0);
        add(0, 4, 1,   0, 98,   0,  1, 0, 7, 0, 0, 1, 0, 0);
        add(0, 4, 1,   1, 33,   0,  1, 0, 7, 0, 0, 1, 0, 0);
        add(0, 4, 1,   0, 97,   0,  1, 0, 7, 0, 0, 1, 0, 0);
        add(0, 4, 1,   1, 44,   0,  0, 0, 7, 0, 0, 1, 0, 0);
        add(0, 4, 1,   0, 0,    1,  0, 1, 11, 0, 0, 1, 0, 0);
        add(0, 4, 1,   0, 0,    0,  0, 0, 11, 0, 0, 1, 0, 0);
        add(0, 4, 1,   0, 0,    1,  0, 1, 22, 0, 0, 1, 0, 0);
        add(0, 4, 1,   0, 0,    0,  0, 0, 22, 0, 0, 1, 0, 0);
        add(0, 4, 1,   0, 0,    1,  0, 1, 33, 0, 0, 1, 0, 0);
        add(0, 4, 1,   0, 0,    1,  0, 1, 44, 1, 0, 0, 1, 0);
        // Illegal configs; rd_en in IDLE ignored
        add(1, 0, 1,   0, 0,    1,  0, 0, 44, 0, 0, 0, 0, 1);
        add(0, 0, 1,   0, 0,    1,  0, 0, 44, 0, 0, 0, 0, 0);
        add(1, 65, 1,  0, 0,    0,  0, 0, 44, 0, 0, 0, 0, 1);
        add(0, 65, 1,  0, 0,    0,  0, 0, 44, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, int'(tbl[i].len), int'(tbl[i].reuse),
                  tbl[i].wv, int'(tbl[i].wd), tbl[i].re);
            exp = {tbl[i].e_wr_ready, tbl[i].e_rd_valid, tbl[i].e_rd_last,
                   tbl[i].e_rd_zero, tbl[i].e_busy, tbl[i].e_done,
                   tbl[i].e_err, tbl[i].e_rd_data};
            chk($sformatf("vec%0d {wr_ready,rd_valid,rd_last,rd_zero,busy,done,err,rd_data}", i),
                32'(outs()), 32'(exp));
        end

        // Reset mid-READ: len=4 {1,2,3,4}, two reads, then async reset
        drive(1, 4, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) drive(0, 4, 1, 1, i, 0);
        drive(0, 4, 1, 0, 0, 1);
        drive(0, 4, 1, 0, 0, 1);
        chk("pre_reset rd_data", 32'(rd_data), 32'd2);
        @(negedge clk);
        rd_en = 1'b0; start = 1'b0; wr_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset {wr_ready,rd_valid,rd_last,rd_zero,busy,done,err,rd_data}", 32'(outs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 2, 1, 0, 0, 0);
        chk("post_reset busy/wr_ready", 32'({busy, wr_ready}), 32'b11);
        drive(0, 2, 1, 1, 9, 0);
        drive(0, 2, 1, 1, 8, 0);
        drive(0, 2, 1, 0, 0, 1);
        chk("post_reset read0 {valid,last,done,data}", 32'({rd_valid, rd_last, done, rd_data}), {21'd0, 3'b100, 8'd9});
        drive(0, 2, 1, 0, 0, 1);
        chk("post_reset read1 {valid,last,done,data}", 32'({rd_valid, rd_last, done, rd_data}), {21'd0, 3'b111, 8'd8});

        // Full depth, data = index, reuse=0 -> exactly one pass
        drive(1, DEPTH, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) drive(0, DEPTH, 0, 1, i, 0);
        nreads = 0;
        ndone  = 0;
        for (int c = 0; c < DEPTH + 16; c++) begin
            drive(0, DEPTH, 0, 0, 0, 1);
            if (rd_valid) begin
                chk($sformatf("full read%0d {last,zero,data}", nreads),
                    32'({rd_last, rd_zero, rd_data}),
                    32'({(nreads == DEPTH - 1), (ZEN && nreads == 0), 8'(nreads)}));
                nreads++;
            end
            if (done) begin
                ndone++;
                chk("full done_with_last", 32'({rd_valid, rd_last}), 32'b11);
            end
        end
        chk("full read_count", 32'(nreads), 32'(DEPTH));
        chk("full done_count", 32'(ndone), 32'd1);
        chk("full idle busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
